// File: rtl/morse_player_pkg.sv
// Shared morse definitions: symbol codes, playback FSM encoding, default timing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package morse_player_pkg;

    // Two-bit symbol codes, common to the recorder, players and translator.
    // 2'b10 is reserved and is treated as empty wherever it appears.
    localparam logic [1:0] SYM_EMPTY = 2'b00;
    localparam logic [1:0] SYM_DOT   = 2'b01;
    localparam logic [1:0] SYM_DASH  = 2'b11;

    // Default timing, in morse units. One unit is 0.5 s at 50 MHz.
    localparam int DEF_UNIT_TICKS = 25000000;
    localparam int DEF_DOT_UNITS  = 1;
    localparam int DEF_DASH_UNITS = 3;
    localparam int DEF_SYM_GAP    = 1;
    localparam int DEF_LETTER_GAP = 3;

    // Width of the unit-count field fed to the unit timer.
    localparam int UNITS_W = 3;

    // Playback FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_MARK  = 3'd3,
        ST_SPACE = 3'd4,
        ST_LGAP  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    // A pair carries a symbol only if it is a dot or a dash.
    // Empty and reserved codes both terminate a word.
    function automatic logic sym_present(input logic [1:0] pair);
        return (pair == SYM_DOT) || (pair == SYM_DASH);
    endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Loadable down-counter that times a whole number of morse units.
// Latency: expired rises exactly units*UNIT_TICKS cycles after the load cycle.
// Backpressure: none. A new load at any time restarts the count.
module morse_unit_timer
    import morse_player_pkg::*;
#(
    parameter int UNIT_TICKS = DEF_UNIT_TICKS,
    parameter int MAX_UNITS  = 3
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               load,
    input  logic [UNITS_W-1:0] units,
    output logic               expired
);

    localparam int CNT_W = $clog2(MAX_UNITS * UNIT_TICKS + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load N-1 so the interval spans exactly N cycles; the last cycle sees zero.
    // A zero-unit load expires immediately rather than underflowing.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            if (units == '0) begin
                cnt_d = '0;
            end else begin
                cnt_d = CNT_W'(units) * CNT_W'(UNIT_TICKS) - CNT_W'(1);
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/morse_player.sv
// Replays stored 10-bit morse words from RAM, in address order, as a timed on/off tone.
// Latency: first mark starts RD_LAT+1 cycles after busy rises. done pulses the cycle after the last mark.
// Backpressure: start is ignored while busy. abort returns to idle on the next cycle.
module morse_player
    import morse_player_pkg::*;
#(
    parameter int UNIT_TICKS = DEF_UNIT_TICKS,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 10,
    parameter int RD_LAT     = 1,
    parameter int DOT_UNITS  = DEF_DOT_UNITS,
    parameter int DASH_UNITS = DEF_DASH_UNITS,
    parameter int SYM_GAP    = DEF_SYM_GAP,
    parameter int LETTER_GAP = DEF_LETTER_GAP
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   num_words,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic              tone,
    output logic              busy,
    output logic              done,
    output logic [1:0]        sym,
    output logic [ADDR_W-1:0] word_idx
);

    localparam int MAX_MU = (DASH_UNITS > DOT_UNITS) ? DASH_UNITS : DOT_UNITS;
    localparam int MAX_GU = (LETTER_GAP > SYM_GAP) ? LETTER_GAP : SYM_GAP;
    localparam int MAX_U  = (MAX_MU > MAX_GU) ? MAX_MU : MAX_GU;
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              tone_q, tone_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        sym_q, sym_d;

    logic               tmr_load;
    logic [UNITS_W-1:0] tmr_units;
    logic               tmr_expired;

    logic [1:0]         cur_pair;
    logic [1:0]         next_pair;
    logic [UNITS_W-1:0] mark_units;
    logic [ADDR_W:0]    idx_plus1;
    logic               last_word;

    morse_unit_timer #(
        .UNIT_TICKS (UNIT_TICKS),
        .MAX_UNITS  (MAX_U)
    ) u_timer (
        .clock   (clock),
        .resetn  (resetn),
        .load    (tmr_load),
        .units   (tmr_units),
        .expired (tmr_expired)
    );

    // Pair about to be (or being) played. In LOAD it comes straight from RAM,
    // because the shift register only captures the word at the end of LOAD.
    always_comb begin
        cur_pair   = (state_q == ST_LOAD) ? ram_q[DATA_W-1 -: 2] : shreg_q[DATA_W-1 -: 2];
        next_pair  = shreg_q[DATA_W-3 -: 2];
        mark_units = (cur_pair == SYM_DASH) ? UNITS_W'(DASH_UNITS) : UNITS_W'(DOT_UNITS);
        idx_plus1  = {1'b0, addr_q} + (ADDR_W+1)'(1);
        last_word  = (idx_plus1 == words_q);
    end

    // Next-state logic. The timer is reloaded on each entry to a timed state,
    // so every mark and gap is cycle-exact with no drift.
    always_comb begin
        state_d   = state_q;
        words_d   = words_q;
        addr_d    = addr_q;
        shreg_d   = shreg_q;
        lat_d     = lat_q;
        tmr_load  = 1'b0;
        tmr_units = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d = '0;
                    if (num_words != '0) begin
                        words_d = num_words;
                        lat_d   = LAT_W'(RD_LAT - 1);
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                if (lat_q == '0) begin
                    state_d = ST_LOAD;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_LOAD: begin
                shreg_d = ram_q;
                if (sym_present(cur_pair)) begin
                    state_d   = ST_MARK;
                    tmr_load  = 1'b1;
                    tmr_units = mark_units;
                end else if (!last_word) begin
                    // An empty word still occupies one letter gap.
                    state_d   = ST_LGAP;
                    tmr_load  = 1'b1;
                    tmr_units = UNITS_W'(LETTER_GAP);
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_MARK: begin
                if (tmr_expired) begin
                    // Zero fill guarantees a word ends after at most five symbols.
                    shreg_d = {shreg_q[DATA_W-3:0], 2'b00};
                    if (sym_present(next_pair)) begin
                        state_d   = ST_SPACE;
                        tmr_load  = 1'b1;
                        tmr_units = UNITS_W'(SYM_GAP);
                    end else if (!last_word) begin
                        state_d   = ST_LGAP;
                        tmr_load  = 1'b1;
                        tmr_units = UNITS_W'(LETTER_GAP);
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SPACE: begin
                if (tmr_expired) begin
                    state_d   = ST_MARK;
                    tmr_load  = 1'b1;
                    tmr_units = mark_units;
                end
            end
            ST_LGAP: begin
                if (tmr_expired) begin
                    // Never reached on the last word, so the address cannot wrap.
                    addr_d  = addr_q + ADDR_W'(1);
                    lat_d   = LAT_W'(RD_LAT - 1);
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // abort overrides everything, including a simultaneous start.
        if (abort) begin
            state_d  = ST_IDLE;
            tmr_load = 1'b0;
        end
    end

    // Outputs are registered from the next state, so tone is high for exactly
    // the cycles the FSM spends in MARK.
    always_comb begin
        tone_d = (state_d == ST_MARK);
        sym_d  = tone_d ? cur_pair : SYM_EMPTY;
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            words_q <= '0;
            addr_q  <= '0;
            shreg_q <= '0;
            lat_q   <= '0;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sym_q   <= SYM_EMPTY;
        end else begin
            state_q <= state_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            shreg_q <= shreg_d;
            lat_q   <= lat_d;
            tone_q  <= tone_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sym_q   <= sym_d;
        end
    end

    assign ram_addr = addr_q;
    assign word_idx = addr_q;
    assign tone     = tone_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sym      = sym_q;

endmodule

// File: tb/tb_morse_player.sv
// Scoreboard bench for morse_player with UNIT_TICKS=4, RD_LAT=1.
// The monitor turns the tone waveform into events (lead silence, mark, gap, done)
// and compares each against the expected event pushed by the stimulus.
module tb_morse_player;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 10;

    localparam logic [1:0] EV_LEAD = 2'd0;
    localparam logic [1:0] EV_MARK = 2'd1;
    localparam logic [1:0] EV_GAP  = 2'd2;
    localparam logic [1:0] EV_DONE = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] len;
        logic [1:0] sym;
        logic [3:0] widx;
    } ev_t;

    logic              clock;
    logic              resetn;
    logic              start;
    logic              abort;
    logic [ADDR_W:0]   num_words;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_q;
    logic              tone;
    logic              busy;
    logic              done;
    logic [1:0]        sym;
    logic [ADDR_W-1:0] word_idx;

    logic [DATA_W-1:0] mem [0:15];

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    morse_player #(
        .UNIT_TICKS (4),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .RD_LAT     (1)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .start     (start),
        .abort     (abort),
        .num_words (num_words),
        .ram_addr  (ram_addr),
        .ram_q     (ram_q),
        .tone      (tone),
        .busy      (busy),
        .done      (done),
        .sym       (sym),
        .word_idx  (word_idx)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous RAM, one cycle of read latency.
    always @(posedge clock) ram_q <= mem[ram_addr];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input int len, input logic [1:0] s, input int w);
        ev_t e;
        e.kind = kind;
        e.len  = 8'(len);
        e.sym  = s;
        e.widx = 4'(w);
        exp_q.push_back(e);
    endtask

    task automatic emit(input ev_t got);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d len=%0d sym=%b widx=%0d, expected no event",
                     got.kind, got.len, got.sym, got.widx);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL event: got kind=%0d len=%0d sym=%b widx=%0d, expected kind=%0d len=%0d sym=%b widx=%0d",
                         got.kind, got.len, got.sym, got.widx, e.kind, e.len, e.sym, e.widx);
            end
        end
    endtask

    // Monitor: measure run lengths of tone at each falling edge.
    int         low_run = 0;
    int         high_run = 0;
    logic       seen_mark = 1'b0;
    logic       prev_tone = 1'b0;
    logic       prev_busy = 1'b0;
    logic [1:0] last_sym = 2'b00;
    logic [3:0] last_widx = 4'd0;

    always @(negedge clock) begin
        ev_t ev;
        if (!resetn) begin
            low_run   = 0;
            high_run  = 0;
            seen_mark = 1'b0;
            prev_tone = 1'b0;
            prev_busy = 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                low_run   = 0;
                seen_mark = 1'b0;
            end
            if (tone) begin
                if (!prev_tone) begin
                    ev.kind = seen_mark ? EV_GAP : EV_LEAD;
                    ev.len  = 8'(low_run);
                    ev.sym  = 2'b00;
                    ev.widx = 4'd0;
                    emit(ev);
                    high_run = 0;
                end
                high_run++;
                last_sym  = sym;
                last_widx = word_idx;
            end else begin
                if (prev_tone) begin
                    ev.kind = EV_MARK;
                    ev.len  = 8'(high_run);
                    ev.sym  = last_sym;
                    ev.widx = last_widx;
                    emit(ev);
                    chk("sym_silent_after_mark", 32'(sym), 32'd0);
                    seen_mark = 1'b1;
                    low_run   = 0;
                end
                low_run++;
            end
            if (done) begin
                ev.kind = EV_DONE;
                ev.len  = seen_mark ? 8'(low_run) : 8'd0;
                ev.sym  = 2'b00;
                ev.widx = 4'd0;
                emit(ev);
                seen_mark = 1'b0;
            end
            prev_tone = tone;
            prev_busy = busy;
        end
    end

    // Call at a falling edge; start is sampled on the following rising edge.
    task automatic start_pulse(input int n);
        start     = 1'b1;
        num_words = 5'(n);
        @(negedge clock);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, returns the number of falling edges waited.
    task automatic wait_done(input string name, output int cyc);
        logic got;
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
            cyc++;
        end
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        repeat (3) @(negedge clock);
        chk({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_tone(input string name, input int w);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (tone && (32'(word_idx) == 32'(w))) begin
                got = 1'b1;
                break;
            end
        end
        chk({name, "_tone_seen"}, 32'(got), 32'd1);
    endtask

    initial begin
        int  cyc;
        logic saw_done;

        resetn    = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        num_words = '0;
        for (int i = 0; i < 16; i++) mem[i] = '0;

        // Reset state
        repeat (2) @(negedge clock);
        chk("rst_tone", 32'(tone), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sym", 32'(sym), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_word_idx", 32'(word_idx), 32'd0);
        resetn = 1'b1;
        @(negedge clock);

        // 1: dot, dash. Lead silence = FETCH + LOAD = 2 cycles.
        mem[0] = 10'b01_11_00_00_00;
        push(EV_LEAD, 2, 2'b00, 0);
        push(EV_MARK, 4, 2'b01, 0);
        push(EV_GAP, 4, 2'b00, 0);
        push(EV_MARK, 12, 2'b11, 0);
        push(EV_DONE, 1, 2'b00, 0);
        start_pulse(1);
        wait_done("t1", cyc);

        // 2: dot word then five dashes. Word gap = 12 + FETCH + LOAD = 14.
        mem[0] = 10'b01_00_00_00_00;
        mem[1] = 10'b11_11_11_11_11;
        push(EV_LEAD, 2, 2'b00, 0);
        push(EV_MARK, 4, 2'b01, 0);
        push(EV_GAP, 14, 2'b00, 0);
        for (int k = 0; k < 5; k++) begin
            if (k != 0) push(EV_GAP, 4, 2'b00, 0);
            push(EV_MARK, 12, 2'b11, 1);
        end
        push(EV_DONE, 1, 2'b00, 0);
        start_pulse(2);
        wait_done("t2", cyc);

        // 3: zero words -> immediate done, address back to 0.
        push(EV_DONE, 0, 2'b00, 0);
        start_pulse(0);
        chk("t3_ram_addr", 32'(ram_addr), 32'd0);
        chk("t3_tone", 32'(tone), 32'd0);
        wait_done("t3", cyc);
        chk("t3_done_within_2", 32'(cyc <= 1), 32'd1);

        // 4: empty first word plays as silence: 2 + 12 + 2 = 16 quiet cycles.
        mem[0] = 10'b00_11_11_00_00;
        mem[1] = 10'b01_00_00_00_00;
        push(EV_LEAD, 16, 2'b00, 0);
        push(EV_MARK, 4, 2'b01, 1);
        push(EV_DONE, 1, 2'b00, 0);
        start_pulse(2);
        wait_done("t4", cyc);

        // 4b: reserved pair 10 ends the word; the dash after it is never played.
        mem[0] = 10'b01_10_11_00_00;
        push(EV_LEAD, 2, 2'b00, 0);
        push(EV_MARK, 4, 2'b01, 0);
        push(EV_DONE, 1, 2'b00, 0);
        start_pulse(1);
        wait_done("t4b", cyc);

        // 5: abort six cycles into the first dash of word 1.
        mem[0] = 10'b01_00_00_00_00;
        mem[1] = 10'b11_11_11_11_11;
        push(EV_LEAD, 2, 2'b00, 0);
        push(EV_MARK, 4, 2'b01, 0);
        push(EV_GAP, 14, 2'b00, 0);
        push(EV_MARK, 6, 2'b11, 1);
        start_pulse(2);
        wait_tone("t5", 1);
        repeat (5) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("t5_tone_after_abort", 32'(tone), 32'd0);
        chk("t5_busy_after_abort", 32'(busy), 32'd0);
        saw_done = done;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (done) saw_done = 1'b1;
        end
        chk("t5_no_done", 32'(saw_done), 32'd0);
        chk("t5_queue_drained", 32'(exp_q.size()), 32'd0);
        push(EV_LEAD, 2, 2'b00, 0);
        push(EV_MARK, 4, 2'b01, 0);
        push(EV_DONE, 1, 2'b00, 0);
        start_pulse(1);
        wait_done("t5_restart", cyc);

        // 6: asynchronous reset mid-mark, checked between clock edges.
        mem[0] = 10'b01_11_00_00_00;
        push(EV_LEAD, 2, 2'b00, 0);
        start_pulse(1);
        wait_tone("t6", 0);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("t6_rst_tone", 32'(tone), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'd0);
        chk("t6_rst_sym", 32'(sym), 32'd0);
        chk("t6_rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("t6_rst_word_idx", 32'(word_idx), 32'd0);
        @(negedge clock);
        #2 resetn = 1'b1;
        @(negedge clock);
        chk("t6_queue_drained", 32'(exp_q.size()), 32'd0);

        // 6b: a start pulse during playback must not disturb timing.
        push(EV_LEAD, 2, 2'b00, 0);
        push(EV_MARK, 4, 2'b01, 0);
        push(EV_GAP, 4, 2'b00, 0);
        push(EV_MARK, 12, 2'b11, 0);
        push(EV_DONE, 1, 2'b00, 0);
        start_pulse(1);
        wait_tone("t6b", 0);
        start_pulse(0);
        wait_done("t6b", cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
